// File: rtl/tpu_cfg_pkg.sv
// Shared definitions for the TPU configuration register block.
// Holds the APB state encoding, the register offsets and the bit positions
// inside the STDN_TPU and ENABLES registers. Addresses are byte offsets.
package tpu_cfg_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2
  } apb_state_e;

  localparam logic [7:0] OFF_ENABLES = 8'h00;
  localparam logic [7:0] OFF_STDN    = 8'h04;
  localparam logic [7:0] OFF_MEAN    = 8'h08;
  localparam logic [7:0] OFF_INV_VAR = 8'h0C;
  localparam logic [7:0] OFF_MAT_A   = 8'h10;
  localparam logic [7:0] OFF_MAT_B   = 8'h14;
  localparam logic [7:0] OFF_MAT_C   = 8'h18;

  // STDN_TPU fields
  localparam int START_BIT = 0;
  localparam int DONE_BIT  = 31;

  // ENABLES fields
  localparam int EN_MATMUL_BIT = 0;
  localparam int EN_NORM_BIT   = 1;
  localparam int EN_POOL_BIT   = 2;
  localparam int EN_ACT_BIT    = 3;

endpackage

// File: rtl/apb_cfg_regs.sv
// APB slave holding the TPU configuration registers.
// Ports:
//   clk, reset            - rising-edge clock, async active-high reset
//   PSEL/PENABLE/PWRITE/PADDR/PWDATA - APB request
//   PRDATA, PREADY        - APB response (zero wait states, both registered)
//   done_tpu              - completion level from the core
//   start_tpu             - run request to the core
//   enable_*              - block enables
//   mean, inv_var         - normalization constants
//   address_mat_a/b/c     - BRAM base addresses
// Every output comes straight from a flop; nothing is combinational from APB.
module apb_cfg_regs
  import tpu_cfg_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32,
  parameter int AWIDTH = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              PSEL,
  input  logic              PENABLE,
  input  logic              PWRITE,
  input  logic [ADDR_W-1:0] PADDR,
  input  logic [DATA_W-1:0] PWDATA,
  output logic [DATA_W-1:0] PRDATA,
  output logic              PREADY,
  input  logic              done_tpu,
  output logic              start_tpu,
  output logic              enable_matmul,
  output logic              enable_norm,
  output logic              enable_pool,
  output logic              enable_activation,
  output logic [7:0]        mean,
  output logic [7:0]        inv_var,
  output logic [AWIDTH-1:0] address_mat_a,
  output logic [AWIDTH-1:0] address_mat_b,
  output logic [AWIDTH-1:0] address_mat_c
);

  apb_state_e        state_q;
  logic [ADDR_W-1:0] addr_q;
  logic              wr_q;
  logic              pready_q;
  logic [DATA_W-1:0] prdata_q;
  logic [DATA_W-1:0] rdata_d;

  logic [3:0]        en_q;
  logic              start_q;
  logic              done_q;
  logic [7:0]        mean_q;
  logic [7:0]        inv_var_q;
  logic [AWIDTH-1:0] mat_a_q;
  logic [AWIDTH-1:0] mat_b_q;
  logic [AWIDTH-1:0] mat_c_q;

  logic setup_req;
  logic wr_commit;
  logic sel_en, sel_stdn, sel_mean, sel_inv, sel_a, sel_b, sel_c;

  // Upper write-data bits land in reserved fields only.
  logic unused_pwdata;
  assign unused_pwdata = ^PWDATA[DATA_W-1:AWIDTH];

  assign setup_req = PSEL & ~PENABLE;
  // ACCESS always exits on the next edge, so that edge is the commit point.
  assign wr_commit = (state_q == ST_ACCESS) & PSEL & PENABLE & PWRITE & wr_q;

  // Full-address compare: unaligned offsets never match and read as zero.
  assign sel_en   = (addr_q == ADDR_W'(OFF_ENABLES));
  assign sel_stdn = (addr_q == ADDR_W'(OFF_STDN));
  assign sel_mean = (addr_q == ADDR_W'(OFF_MEAN));
  assign sel_inv  = (addr_q == ADDR_W'(OFF_INV_VAR));
  assign sel_a    = (addr_q == ADDR_W'(OFF_MAT_A));
  assign sel_b    = (addr_q == ADDR_W'(OFF_MAT_B));
  assign sel_c    = (addr_q == ADDR_W'(OFF_MAT_C));

  always_comb begin
    rdata_d = '0;
    if (sel_en) begin
      rdata_d[3:0] = en_q;
    end else if (sel_stdn) begin
      rdata_d[START_BIT] = start_q;
      rdata_d[DONE_BIT]  = done_q;
    end else if (sel_mean) begin
      rdata_d[7:0] = mean_q;
    end else if (sel_inv) begin
      rdata_d[7:0] = inv_var_q;
    end else if (sel_a) begin
      rdata_d[AWIDTH-1:0] = mat_a_q;
    end else if (sel_b) begin
      rdata_d[AWIDTH-1:0] = mat_b_q;
    end else if (sel_c) begin
      rdata_d[AWIDTH-1:0] = mat_c_q;
    end
  end

  // APB protocol FSM; PREADY and PRDATA are registered alongside the state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      addr_q   <= '0;
      wr_q     <= 1'b0;
      pready_q <= 1'b0;
      prdata_q <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          pready_q <= 1'b0;
          // PSEL with PENABLE already high has no setup phase: ignored.
          if (setup_req) begin
            state_q <= ST_SETUP;
            addr_q  <= PADDR;
            wr_q    <= PWRITE;
          end
        end
        ST_SETUP: begin
          state_q  <= ST_ACCESS;
          pready_q <= 1'b1;
          // Captured before this edge's register update (done shows old value).
          if (!wr_q) prdata_q <= rdata_d;
        end
        ST_ACCESS: begin
          pready_q <= 1'b0;
          if (setup_req) begin
            state_q <= ST_SETUP;
            addr_q  <= PADDR;
            wr_q    <= PWRITE;
          end else begin
            state_q <= ST_IDLE;
          end
        end
        default: begin
          state_q  <= ST_IDLE;
          pready_q <= 1'b0;
        end
      endcase
    end
  end

  // Configuration registers and start/done handshake.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      en_q      <= '0;
      start_q   <= 1'b0;
      done_q    <= 1'b0;
      mean_q    <= '0;
      inv_var_q <= '0;
      mat_a_q   <= '0;
      mat_b_q   <= '0;
      mat_c_q   <= '0;
    end else begin
      if (wr_commit) begin
        if (sel_en)   en_q      <= PWDATA[3:0];
        if (sel_mean) mean_q    <= PWDATA[7:0];
        if (sel_inv)  inv_var_q <= PWDATA[7:0];
        if (sel_a)    mat_a_q   <= PWDATA[AWIDTH-1:0];
        if (sel_b)    mat_b_q   <= PWDATA[AWIDTH-1:0];
        if (sel_c)    mat_c_q   <= PWDATA[AWIDTH-1:0];
      end
      if (wr_commit && sel_stdn) begin
        if (!PWDATA[START_BIT]) begin
          // Stop: clear beats a coincident done_tpu.
          start_q <= 1'b0;
          done_q  <= 1'b0;
        end else if (!start_q) begin
          start_q <= 1'b1;
        end
        // start=1 while already running: both bits held.
      end else if (start_q && done_tpu) begin
        done_q <= 1'b1;  // sticky until a stop write
      end
    end
  end

  assign PRDATA            = prdata_q;
  assign PREADY            = pready_q;
  assign start_tpu         = start_q;
  assign enable_matmul     = en_q[EN_MATMUL_BIT];
  assign enable_norm       = en_q[EN_NORM_BIT];
  assign enable_pool       = en_q[EN_POOL_BIT];
  assign enable_activation = en_q[EN_ACT_BIT];
  assign mean              = mean_q;
  assign inv_var           = inv_var_q;
  assign address_mat_a     = mat_a_q;
  assign address_mat_b     = mat_b_q;
  assign address_mat_c     = mat_c_q;

endmodule

// File: doc/apb_cfg_regs.md
APB_CFG_REGS -- requirements
Module: apb_cfg_regs

Interface
REQ-001 SHALL have parameters: ADDR_W, default 8, APB address width; DATA_W, default 32, APB data width; AWIDTH, default 10, matrix base-address width.
REQ-002 SHALL use one clock and an asynchronous, active-high reset, with the ports listed below.
REQ-003 SHALL have ports (name, direction, width, meaning):
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous active-high reset
- PSEL  in  1  APB select
- PENABLE  in  1  APB enable
- PWRITE  in  1  1 = write, 0 = read
- PADDR  in  ADDR_W  byte address
- PWDATA  in  DATA_W  write data
- PRDATA  out  DATA_W  read data
- PREADY  out  1  transfer complete
- done_tpu  in  1  core completion level
- start_tpu  out  1  run request to core
- enable_matmul, enable_norm, enable_pool, enable_activation  out  1 each  block enables
- mean, inv_var  out  8 each  normalization constants
- address_mat_a, address_mat_b, address_mat_c  out  AWIDTH each  BRAM base addresses

Function
REQ-004 SHALL implement an APB state machine with states IDLE, SETUP and ACCESS.
- IDLE to SETUP on PSEL=1 and PENABLE=0.
- SETUP to ACCESS unconditionally.
- ACCESS to SETUP if PSEL=1 and PENABLE=0; otherwise ACCESS to IDLE.
REQ-005 SHALL drive PREADY=1 only in ACCESS; there are zero wait states, so each transfer takes 2 cycles from setup.
REQ-006 SHALL ignore PSEL=1 with PENABLE=1 while in IDLE (access without setup): no state change, no register update.
REQ-007 SHALL latch PADDR and PWRITE on entry to SETUP; PADDR changes during ACCESS SHALL be ignored.
REQ-008 SHALL commit a write on the clock edge that leaves ACCESS, when PWRITE=1, PSEL=1 and PENABLE=1, using the PWDATA present at that edge.
REQ-009 SHALL register PRDATA on the SETUP-to-ACCESS edge for reads, and SHALL hold it until the next read; writes SHALL NOT change PRDATA.
REQ-010 SHALL use this register map (bits not listed are reserved, read 0 and ignore writes):
- 0x00 ENABLES: bit0 matmul, bit1 norm, bit2 pool, bit3 activation.
- 0x04 STDN_TPU: bit0 start (read/write), bit31 done (read-only).
- 0x08 MEAN [7:0].
- 0x0C INV_VAR [7:0].
- 0x10 MATRIX_A, 0x14 MATRIX_B, 0x18 MATRIX_C: [AWIDTH-1:0].
REQ-011 SHALL treat unmapped or unaligned addresses as follows: reads return 0, writes are ignored, and PREADY timing is unchanged.
REQ-012 SHALL drive start_tpu and all configuration outputs directly from their register flops, with no combinational path from the APB inputs.
REQ-013 SHALL set the done bit on any edge where start=1 and done_tpu=1; done SHALL remain sticky until cleared.
REQ-014 SHALL clear done on a committed STDN_TPU write with bit0=0, and clear SHALL win over a simultaneous done_tpu=1.
REQ-015 SHALL, on a committed STDN_TPU write with bit0=1 while start is already 1, leave both start and done unchanged.
REQ-016 SHALL return, on an STDN_TPU read in the same cycle that done is set, the pre-update value (done=0).
REQ-017 SHALL ignore done_tpu while start=0.

Reset
REQ-018 SHALL, while reset=1, asynchronously force:
- state to IDLE and PREADY to 0;
- PRDATA to 0;
- all registers, start_tpu and done to 0.
REQ-019 SHALL abandon any in-flight transfer on reset mid-SETUP or mid-ACCESS: no partial write, and the next transfer needs a fresh setup phase.

Structure
REQ-020 SHALL take the register offsets, STDN bit positions (START_BIT=0, DONE_BIT=31), ENABLES bit positions and the state enumeration from shared package tpu_cfg_pkg.
REQ-021 SHALL be a single module with no sub-modules; the register decode and the FSM SHALL be coded inline.

Verification
REQ-022 SHALL verify each write/read-back:
- write 0x00=0x0000000F, then read 0x00 gives 0x0000000F and all four enables are 1;
- write 0x0000000D, then enable_norm=0.
REQ-023 SHALL verify addresses: write 0x10=0x8, 0x14=0x0, 0x18=0x20 gives address_mat_a=8, address_mat_b=0, address_mat_c=0x20, and reads match.
REQ-024 SHALL verify the start/done flow:
- write 0x04=1 gives start_tpu=1 one cycle after ACCESS;
- raise done_tpu gives a later read of 0x04 = 0x80000001;
- write 0x04=0 gives 0x00000000;
- restart with write 0x04=1 gives done=0 until done_tpu is raised again.
REQ-025 SHALL verify a simultaneous clear: a committed write 0x04=0 on the same edge as done_tpu=1 gives a read of 0x00000000.
REQ-026 SHALL verify protocol edge cases:
- a write to 0x40 is ignored, and a read of 0x40 returns 0;
- PENABLE=1 without a setup phase causes no register change;
- reset asserted during ACCESS of a write 0x08=0x55 leaves mean=0.
REQ-027 SHALL verify PRDATA hold: read 0x08 after writing 0x08=0x01, then deassert PSEL; PRDATA SHALL stay 0x00000001 for at least 3 idle cycles.
